// File: rtl/phy_rx_sync_ctrl.sv
// Link synchronization controller: comma hunt, bit-slip requests, payload forwarding, loss of sync.
// Optional build macro SYNC_STATS_EN adds the sync_loss_cnt output (saturating ACTIVE->HUNT count).
module phy_rx_sync_ctrl #(
  parameter logic [7:0]  COMMA        = 8'hBC,
  parameter int unsigned SYNC_CNT     = 4,
  parameter int unsigned SLIP_TIMEOUT = 8,
  parameter int unsigned ERR_LIMIT    = 3
) (
  input  logic       clk_4f,
  input  logic       reset,
  input  logic [7:0] sp_data,
  input  logic       sp_valid,
  input  logic       code_err,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active,
  output logic       bitslip
`ifdef SYNC_STATS_EN
  ,
  output logic [7:0] sync_loss_cnt
`endif
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned BC_W   = 4;
  localparam int unsigned SLIP_W = 8;
  localparam int unsigned ERR_W  = 4;

  localparam logic [BC_W-1:0]   SYNC_LIM = BC_W'(SYNC_CNT);
  localparam logic [SLIP_W-1:0] SLIP_LIM = SLIP_W'(SLIP_TIMEOUT);
  localparam logic [ERR_W-1:0]  ERR_LIM  = ERR_W'(ERR_LIMIT);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  state_e              state_q;
  logic [BC_W-1:0]     bc_cnt_q;
  logic [SLIP_W-1:0]   slip_cnt_q;
  logic [ERR_W-1:0]    err_cnt_q;
  logic [DATA_W-1:0]   data_q;
  logic                valid_q;
  logic                active_q;
  logic                bitslip_q;

  logic                is_comma_c;
  logic [BC_W-1:0]     bc_inc_c;
  logic [SLIP_W-1:0]   slip_inc_c;
  logic [ERR_W-1:0]    err_inc_c;

  assign is_comma_c = (sp_data == COMMA);
  assign bc_inc_c   = bc_cnt_q + BC_W'(1);
  assign slip_inc_c = slip_cnt_q + SLIP_W'(1);
  assign err_inc_c  = err_cnt_q + ERR_W'(1);

`ifdef SYNC_STATS_EN
  logic [7:0] loss_cnt_q;
`endif

  // Sync FSM with registered outputs; idle cycles (sp_valid=0) freeze everything but the pulses.
  always_ff @(posedge clk_4f or posedge reset) begin
    if (reset) begin
      state_q    <= HUNT;
      bc_cnt_q   <= '0;
      slip_cnt_q <= '0;
      err_cnt_q  <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      active_q   <= 1'b0;
      bitslip_q  <= 1'b0;
`ifdef SYNC_STATS_EN
      loss_cnt_q <= '0;
`endif
    end else begin
      valid_q   <= 1'b0;
      bitslip_q <= 1'b0;
      if (sp_valid) begin
        unique case (state_q)
          HUNT: begin
            if (is_comma_c) begin
              slip_cnt_q <= '0;
              if (SYNC_LIM == BC_W'(1)) begin
                state_q  <= ACTIVE;
                active_q <= 1'b1;
                bc_cnt_q <= '0;
              end else begin
                state_q  <= SYNC;
                bc_cnt_q <= BC_W'(1);
              end
            end else if (slip_inc_c >= SLIP_LIM) begin
              // A pulse on the previous cycle defers this one so bitslip never fires back to back.
              if (!bitslip_q) begin
                bitslip_q  <= 1'b1;
                slip_cnt_q <= '0;
              end else begin
                slip_cnt_q <= SLIP_LIM - SLIP_W'(1);
              end
            end else begin
              slip_cnt_q <= slip_inc_c;
            end
          end

          SYNC: begin
            if (is_comma_c && !code_err) begin
              if (bc_inc_c >= SYNC_LIM) begin
                state_q  <= ACTIVE;
                active_q <= 1'b1;
                bc_cnt_q <= '0;
              end else begin
                bc_cnt_q <= bc_inc_c;
              end
            end else begin
              state_q  <= HUNT;
              bc_cnt_q <= '0;
            end
          end

          ACTIVE: begin
            if (code_err) begin
              if (err_inc_c >= ERR_LIM) begin
                state_q    <= HUNT;
                active_q   <= 1'b0;
                err_cnt_q  <= '0;
                bc_cnt_q   <= '0;
                slip_cnt_q <= '0;
`ifdef SYNC_STATS_EN
                if (loss_cnt_q != 8'hFF) begin
                  loss_cnt_q <= loss_cnt_q + 8'd1;
                end
`endif
              end else begin
                err_cnt_q <= err_inc_c;
              end
            end else if (is_comma_c) begin
              err_cnt_q <= '0;
            end else begin
              data_q  <= sp_data;
              valid_q <= 1'b1;
            end
          end

          default: begin
            state_q  <= HUNT;
            active_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;
  assign active    = active_q;
  assign bitslip   = bitslip_q;

`ifdef SYNC_STATS_EN
  assign sync_loss_cnt = loss_cnt_q;
`endif

endmodule

// File: tb/tb_phy_rx_sync_ctrl.sv
// Directed scoreboard bench for phy_rx_sync_ctrl; expected outputs are queued per driven byte.
module tb_phy_rx_sync_ctrl;

  logic       clk_4f;
  logic       reset;
  logic [7:0] sp_data;
  logic       sp_valid;
  logic       code_err;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;
  logic       bitslip;
`ifdef SYNC_STATS_EN
  logic [7:0] sync_loss_cnt;
`endif

  phy_rx_sync_ctrl dut (
    .clk_4f        (clk_4f),
    .reset         (reset),
    .sp_data       (sp_data),
    .sp_valid      (sp_valid),
    .code_err      (code_err),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .active        (active),
    .bitslip       (bitslip)
`ifdef SYNC_STATS_EN
    ,
    .sync_loss_cnt (sync_loss_cnt)
`endif
  );

  initial clk_4f = 1'b0;
  always #5 clk_4f = ~clk_4f;

  typedef struct packed {
    logic       act;
    logic       vld;
    logic       slip;
    logic [7:0] dat;
  } exp_t;

  exp_t       sb_q[$];
  int         n_cmp = 0;
  int         n_mis = 0;
  logic [7:0] exp_data = 8'h00;

  task automatic check_outputs(input string tag, input exp_t x);
    n_cmp++;
    assert (active === x.act) else begin
      n_mis++;
      $error("FAIL %s active: got %b expected %b", tag, active, x.act);
    end
    n_cmp++;
    assert (valid_out === x.vld) else begin
      n_mis++;
      $error("FAIL %s valid_out: got %b expected %b", tag, valid_out, x.vld);
    end
    n_cmp++;
    assert (bitslip === x.slip) else begin
      n_mis++;
      $error("FAIL %s bitslip: got %b expected %b", tag, bitslip, x.slip);
    end
    n_cmp++;
    assert (data_out === x.dat) else begin
      n_mis++;
      $error("FAIL %s data_out: got %h expected %h", tag, data_out, x.dat);
    end
  endtask

  // Drive one byte on the falling edge, queue its expectation, compare 1 time unit after the next rising edge.
  task automatic step(input string tag, input logic [7:0] d, input logic v, input logic e,
                      input logic x_act, input logic x_vld, input logic x_slip);
    exp_t x;
    @(negedge clk_4f);
    sp_data  = d;
    sp_valid = v;
    code_err = e;
    if (x_vld) exp_data = d;
    x.act  = x_act;
    x.vld  = x_vld;
    x.slip = x_slip;
    x.dat  = exp_data;
    sb_q.push_back(x);
    @(posedge clk_4f);
    #1;
    x = sb_q.pop_front();
    check_outputs(tag, x);
  endtask

`ifdef SYNC_STATS_EN
  task automatic check_loss(input string tag, input logic [7:0] x);
    n_cmp++;
    assert (sync_loss_cnt === x) else begin
      n_mis++;
      $error("FAIL %s sync_loss_cnt: got %0d expected %0d", tag, sync_loss_cnt, x);
    end
  endtask
`endif

  initial begin
    exp_t z;
    z = '0;
    reset    = 1'b1;
    sp_data  = 8'h00;
    sp_valid = 1'b0;
    code_err = 1'b0;
    repeat (2) @(posedge clk_4f);
    #1;
    check_outputs("reset", z);
`ifdef SYNC_STATS_EN
    check_loss("reset", 8'd0);
`endif
    @(negedge clk_4f);
    reset = 1'b0;

    // Four commas: active on the edge after the fourth, no payload.
    for (int i = 0; i < 4; i++) step("sync4", 8'hBC, 1'b1, 1'b0, i == 3, 1'b0, 1'b0);

    // Payload forwarding with a comma stripped and an idle cycle.
    step("pay_dd", 8'hDD, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step("pay_45", 8'h45, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step("pay_bc", 8'hBC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step("pay_aa", 8'hAA, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step("pay_13", 8'h13, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step("pay_gap", 8'h99, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Three code errors drop sync.
    step("err1", 8'h77, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step("err2", 8'h77, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step("err3", 8'h77, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef SYNC_STATS_EN
    check_loss("loss1", 8'd1);
`endif

    // Broken comma run returns to HUNT without a bitslip.
    for (int i = 0; i < 3; i++) step("partial_bc", 8'hBC, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step("partial_15", 8'h15, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // A full fresh run of four is needed, proving the count restarted.
    for (int i = 0; i < 4; i++) step("resync", 8'hBC, 1'b1, 1'b0, i == 3, 1'b0, 1'b0);

    // A comma between error bursts clears the error count.
    step("e_a1", 8'h31, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step("e_a2", 8'h32, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step("e_bc", 8'hBC, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step("e_b1", 8'h33, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step("e_b2", 8'h34, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step("e_b3", 8'h35, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef SYNC_STATS_EN
    check_loss("loss2", 8'd2);
`endif

    // Bitslip after 8 non-comma bytes (idle cycle and code_err do not matter), again after 16.
    for (int i = 0; i < 4; i++) step("slip_a", 8'h5E, 1'b1, i[0], 1'b0, 1'b0, 1'b0);
    step("slip_gap", 8'h5E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step("slip_b", 8'h5E, 1'b1, 1'b0, 1'b0, 1'b0, i == 3);
    for (int i = 0; i < 8; i++) step("slip_c", 8'h5E, 1'b1, 1'b0, 1'b0, 1'b0, i == 7);
    step("slip_after", 8'h5E, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset between edges while a payload byte is on the outputs.
    for (int i = 0; i < 4; i++) step("pre_rst", 8'hBC, 1'b1, 1'b0, i == 3, 1'b0, 1'b0);
    step("pre_rst_dd", 8'hDD, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    exp_data = 8'h00;
    check_outputs("async_rst", z);
`ifdef SYNC_STATS_EN
    check_loss("async_rst", 8'd0);
`endif
    sp_valid = 1'b0;
    @(posedge clk_4f);
    @(negedge clk_4f);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step("post_rst", 8'hBC, 1'b1, 1'b0, i == 3, 1'b0, 1'b0);
    step("post_rst_42", 8'h42, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
